// File: rtl/conv_lb_sched.sv
// -----------------------------------------------------------------------------
// conv_pkg / conv_lb_sched
//
// Line-buffer scheduler for the convolution front end. Rows of a raster pixel
// stream are rotated across a ring of KERNEL_N line buffers: the current row is
// pushed into one buffer while the previously stored rows are popped from the
// others, column-aligned. The current pixel and its sideband travel through an
// LB_LAT-deep delay pipe so they line up with the line-buffer read data, and
// leave as one vertical window column with row-validity and rotation info.
//
// Optional feature: define CONV_LB_SCHED_LEN_CHK_EN to add a line-length
// checker and the sticky err_o output.
//
// Ports:
//   clk, arst_n            clock, asynchronous active-low reset
//   in_vld_i / in_rdy_o    input pixel handshake
//   in_dat_i               input pixel
//   in_sof/sol/eol/eof_i   frame/line markers, qualified by in_vld_i
//   lb_push_o              per-buffer push (one-hot or zero)
//   lb_pop_o               per-buffer pop for all previously stored rows
//   lb_dat_o               write data to all buffers (= in_dat_i)
//   lb_sol_o, lb_eol_o     line markers to all buffers on accept
//   out_vld_o / out_rdy_i  output column handshake
//   out_dat_o              current-row pixel delayed by LB_LAT
//   out_rows_vld_o         bit k set: row r-1-k holds real data
//   out_rot_o              index of the buffer holding row r-1
//   out_sol/eol/eof_o      delayed markers
//   err_o                  sticky line-length error (CONV_LB_SCHED_LEN_CHK_EN)
// -----------------------------------------------------------------------------
package conv_pkg;
    localparam int PIXEL_W     = 8;
    localparam int IMAGE_MAX_W = 1920;
endpackage

module conv_lb_sched #(
    parameter int KERNEL_N    = 3,
    parameter int LB_LAT      = 2,
    parameter int IMAGE_MAX_W = conv_pkg::IMAGE_MAX_W
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          in_vld_i,
    output logic                          in_rdy_o,
    input  logic [conv_pkg::PIXEL_W-1:0]  in_dat_i,
    input  logic                          in_sof_i,
    input  logic                          in_sol_i,
    input  logic                          in_eol_i,
    input  logic                          in_eof_i,
    output logic [KERNEL_N-1:0]           lb_push_o,
    output logic [KERNEL_N-1:0]           lb_pop_o,
    output logic [conv_pkg::PIXEL_W-1:0]  lb_dat_o,
    output logic                          lb_sol_o,
    output logic                          lb_eol_o,
    output logic                          out_vld_o,
    input  logic                          out_rdy_i,
    output logic [conv_pkg::PIXEL_W-1:0]  out_dat_o,
    output logic [KERNEL_N-2:0]           out_rows_vld_o,
    output logic [$clog2(KERNEL_N)-1:0]   out_rot_o,
    output logic                          out_sol_o,
    output logic                          out_eol_o,
    output logic                          out_eof_o
`ifdef CONV_LB_SCHED_LEN_CHK_EN
    ,
    output logic                          err_o
`endif
);

    localparam int PIXEL_W = conv_pkg::PIXEL_W;
    localparam int PTR_W   = $clog2(KERNEL_N);
    localparam int MASK_W  = KERNEL_N - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rows_q, rows_d;
    logic               adv;
    logic               acc;
    logic               inner_busy;
    logic [PTR_W-1:0]   eff_wr;
    logic [PTR_W-1:0]   eff_rows;
    logic               sol_eff;
    logic [MASK_W-1:0]  s0_mask;
    logic [PTR_W-1:0]   s0_rot;

    logic [LB_LAT-1:0]  pipe_vld_q, pipe_vld_d;
    logic [LB_LAT-1:0]  pipe_sol_q, pipe_sol_d;
    logic [LB_LAT-1:0]  pipe_eol_q, pipe_eol_d;
    logic [LB_LAT-1:0]  pipe_eof_q, pipe_eof_d;
    logic [MASK_W-1:0]  pipe_mask_q [LB_LAT];
    logic [MASK_W-1:0]  pipe_mask_d [LB_LAT];
    logic [PTR_W-1:0]   pipe_rot_q  [LB_LAT];
    logic [PTR_W-1:0]   pipe_rot_d  [LB_LAT];
    logic [PIXEL_W-1:0] pipe_dat_q  [LB_LAT];
    logic [PIXEL_W-1:0] pipe_dat_d  [LB_LAT];

    // Buffer index n rows behind ptr in the ring.
    function automatic logic [PTR_W-1:0] ring_back(input logic [PTR_W-1:0] ptr, input int n);
        int idx;
        idx = (int'(ptr) + KERNEL_N - n) % KERNEL_N;
        return idx[PTR_W-1:0];
    endfunction

    function automatic logic [PTR_W-1:0] ring_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(KERNEL_N - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // ---- input handshake -----------------------------------------------------
    always_comb begin
        adv      = out_rdy_i | ~out_vld_o;
        in_rdy_o = 1'b0;
        case (state_q)
            ST_IDLE:   in_rdy_o = adv & in_sof_i;
            ST_ACTIVE: in_rdy_o = adv;
            default:   in_rdy_o = 1'b0;
        endcase
    end

    assign acc      = in_vld_i & in_rdy_o;
    assign lb_dat_o = in_dat_i;

    // ---- row rotation and line-buffer commands -------------------------------
    always_comb begin
        // A sof pixel is row 0 of a fresh frame whatever the stored state says.
        eff_wr   = in_sof_i ? '0 : wr_ptr_q;
        eff_rows = in_sof_i ? '0 : rows_q;
        sol_eff  = in_sol_i | in_sof_i;
        wr_ptr_d = wr_ptr_q;
        rows_d   = rows_q;
        if (acc) begin
            wr_ptr_d = eff_wr;
            rows_d   = eff_rows;
            if (in_eol_i) begin
                wr_ptr_d = ring_next(eff_wr);
                rows_d   = (eff_rows == PTR_W'(KERNEL_N - 1)) ? eff_rows : eff_rows + PTR_W'(1);
            end
        end

        lb_push_o = '0;
        lb_pop_o  = '0;
        s0_mask   = '0;
        for (int j = 0; j < KERNEL_N; j++) begin
            lb_push_o[j] = acc && (int'(eff_wr) == j);
        end
        for (int k = 0; k < KERNEL_N - 1; k++) begin
            if (int'(eff_rows) > k) begin
                s0_mask[k]                      = 1'b1;
                lb_pop_o[ring_back(eff_wr, k + 1)] = acc;
            end
        end
        s0_rot   = ring_back(eff_wr, 1);
        lb_sol_o = acc & sol_eff;
        lb_eol_o = acc & in_eol_i;
    end

    // ---- frame state machine -------------------------------------------------
    always_comb begin
        inner_busy = 1'b0;
        for (int s = 0; s < LB_LAT - 1; s++) begin
            inner_busy = inner_busy | pipe_vld_q[s];
        end
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (acc) begin
                    state_d = (in_eol_i & in_eof_i) ? ST_DRAIN : ST_ACTIVE;
                end
            end
            // Leave once the last valid stage is being handed off.
            ST_DRAIN: begin
                if (!inner_busy && adv) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- delay pipe: stage 0 loads the accepted pixel, then shifts on adv -----
    always_comb begin
        pipe_vld_d  = pipe_vld_q;
        pipe_sol_d  = pipe_sol_q;
        pipe_eol_d  = pipe_eol_q;
        pipe_eof_d  = pipe_eof_q;
        pipe_mask_d = pipe_mask_q;
        pipe_rot_d  = pipe_rot_q;
        pipe_dat_d  = pipe_dat_q;
        if (adv) begin
            pipe_vld_d[0]  = acc;
            pipe_sol_d[0]  = sol_eff;
            pipe_eol_d[0]  = in_eol_i;
            pipe_eof_d[0]  = in_eof_i;
            pipe_mask_d[0] = s0_mask;
            pipe_rot_d[0]  = s0_rot;
            pipe_dat_d[0]  = in_dat_i;
            for (int s = 1; s < LB_LAT; s++) begin
                pipe_vld_d[s]  = pipe_vld_q[s-1];
                pipe_sol_d[s]  = pipe_sol_q[s-1];
                pipe_eol_d[s]  = pipe_eol_q[s-1];
                pipe_eof_d[s]  = pipe_eof_q[s-1];
                pipe_mask_d[s] = pipe_mask_q[s-1];
                pipe_rot_d[s]  = pipe_rot_q[s-1];
                pipe_dat_d[s]  = pipe_dat_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rows_q     <= '0;
            pipe_vld_q <= '0;
            pipe_sol_q <= '0;
            pipe_eol_q <= '0;
            pipe_eof_q <= '0;
            for (int s = 0; s < LB_LAT; s++) begin
                pipe_mask_q[s] <= '0;
                pipe_rot_q[s]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rows_q      <= rows_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_sol_q  <= pipe_sol_d;
            pipe_eol_q  <= pipe_eol_d;
            pipe_eof_q  <= pipe_eof_d;
            pipe_mask_q <= pipe_mask_d;
            pipe_rot_q  <= pipe_rot_d;
        end
    end

    // Pixel data is qualified by pipe_vld_q and needs no reset.
    always_ff @(posedge clk) begin
        pipe_dat_q <= pipe_dat_d;
    end

    // ---- output stage --------------------------------------------------------
    assign out_vld_o      = pipe_vld_q[LB_LAT-1];
    assign out_dat_o      = pipe_dat_q[LB_LAT-1];
    assign out_sol_o      = pipe_sol_q[LB_LAT-1];
    assign out_eol_o      = pipe_eol_q[LB_LAT-1];
    assign out_eof_o      = pipe_eof_q[LB_LAT-1];
    assign out_rows_vld_o = pipe_mask_q[LB_LAT-1];
    assign out_rot_o      = pipe_rot_q[LB_LAT-1];

`ifdef CONV_LB_SCHED_LEN_CHK_EN
    localparam int               COL_W   = $clog2(IMAGE_MAX_W + 2);
    // Saturating one past the maximum keeps over-long lines detectable.
    localparam logic [COL_W-1:0] COL_SAT = COL_W'(IMAGE_MAX_W + 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] first_len_q, first_len_d;
    logic [COL_W-1:0] col_now;
    logic             len_vld_q, len_vld_d;
    logic             err_q, err_d;

    always_comb begin
        col_d       = col_q;
        first_len_d = first_len_q;
        len_vld_d   = len_vld_q;
        err_d       = err_q;
        if (sol_eff) begin
            col_now = COL_W'(1);
        end else if (col_q == COL_SAT) begin
            col_now = col_q;
        end else begin
            col_now = col_q + COL_W'(1);
        end
        if (acc) begin
            col_d = col_now;
            if (in_sof_i) begin
                len_vld_d = 1'b0;
            end
            if (col_now > COL_W'(IMAGE_MAX_W)) begin
                err_d = 1'b1;
            end
            if (in_eol_i) begin
                if (!len_vld_q || in_sof_i) begin
                    first_len_d = col_now;
                    len_vld_d   = 1'b1;
                end else if (col_now != first_len_q) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            col_q       <= '0;
            first_len_q <= '0;
            len_vld_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            col_q       <= col_d;
            first_len_q <= first_len_d;
            len_vld_q   <= len_vld_d;
            err_q       <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_max_w;
    assign unused_max_w = (IMAGE_MAX_W > 0);
`endif

endmodule
